// File: rtl/alu_divider.sv
// alu_divider: iterative restoring divider, one quotient bit per clk, result in ALU out/flag format.
// Latency: B!=0 -> done after WIDTH+1 edges counting the accept edge; B==0 -> done right after accept.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted (back-to-back).
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start, A, B     request pulse with dividend/divisor, sampled when not busy
//   is_signed       two's-complement mode select (only when ALU_DIV_SIGNED_EN is defined)
//   busy, done      division in progress / one-cycle completion pulse
//   out             {remainder, quotient}, held until the next result is written
//   Sign_Flag       out MSB;  Zero_Flag: out == 0
//   div_by_zero     set with a B==0 result, cleared on the next accepted start
//
// Optional feature macro: ALU_DIV_SIGNED_EN (adds is_signed, truncating signed division).
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef ALU_DIV_SIGNED_EN
  input  logic                 is_signed,
`endif
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out,
  output logic                 Sign_Flag,
  output logic                 Zero_Flag,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_out;
  logic               r_dbz;

  logic               w_sgn;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_accept;
  logic               w_b_zero;
  logic               w_last;
  logic [WIDTH:0]     w_shift_rem;
  logic [WIDTH+1:0]   w_trial;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_rem_fin;
  logic [WIDTH-1:0]   w_quo_fin;

`ifdef ALU_DIV_SIGNED_EN
  assign w_sgn = is_signed;
`else
  assign w_sgn = 1'b0;
`endif

  // Divide magnitudes; signs are reapplied when the last step writes out.
  // The magnitude of the most negative value is itself as an unsigned number.
  assign w_a_neg  = w_sgn & A[WIDTH-1];
  assign w_b_neg  = w_sgn & B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-A) : A;
  assign w_b_mag  = w_b_neg ? (-B) : B;

  assign w_accept = start && (r_state != S_RUN);
  assign w_b_zero = (B == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Restoring step. The shifted partial remainder can reach 2*divisor-1, so it
  // carries one extra bit, and the trial subtraction one more for the borrow.
  assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = {1'b0, w_shift_rem} - {2'b00, r_div};
  assign w_borrow    = w_trial[WIDTH+1];
  assign w_rem_nxt   = w_borrow ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt   = {r_quo[WIDTH-2:0], ~w_borrow};

  // Truncating division: quotient negative when signs differ, remainder follows the dividend.
  assign w_rem_fin   = r_neg_r ? (-w_rem_nxt) : w_rem_nxt;
  assign w_quo_fin   = r_neg_q ? (-w_quo_nxt) : w_quo_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = w_b_zero ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_out   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_a_mag;
      r_div   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dbz   <= w_b_zero;
      // Divide-by-zero completes immediately; the raw dividend is the remainder.
      if (w_b_zero) begin
        r_out <= {A, {WIDTH{1'b1}}};
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (w_last) begin
        r_out <= {w_rem_fin, w_quo_fin};
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign out         = r_out;
  assign Sign_Flag   = r_out[2*WIDTH-1];
  assign Zero_Flag   = (r_out == '0);
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed and random checks of alu_divider against a behavioural division model.
// Expected results are queued at issue time and popped when done pulses.
// Signed cases are compiled in only when ALU_DIV_SIGNED_EN is defined.
module tb_alu_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] out;
  logic        Sign_Flag;
  logic        Zero_Flag;
  logic        div_by_zero;

  int          n_checks;
  int          n_errors;
  logic [64:0] sb_q[$];
  logic [63:0] last_out;

  alu_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef ALU_DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .Sign_Flag   (Sign_Flag),
    .Zero_Flag   (Zero_Flag),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Returns {div_by_zero, remainder, quotient}.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [64:0] res;
    if (b == 32'd0) begin
      res = {1'b1, a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = sa / sb;
      r   = sa % sb;
      res = {1'b0, r[31:0], q[31:0]};
    end else begin
      res = {1'b0, a % b, a / b};
    end
    return res;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn, input bit push);
    if (push) sb_q.push_back(model(a, b, sgn));
    A         = a;
    B         = b;
    is_signed = sgn;
    start     = 1'b1;
  endtask

  // Waits for done (bounded), checks latency counted from the accept edge,
  // checks out is held during the run, then compares against the scoreboard.
  task automatic wait_done(input int exp_lat, input int glitch_at);
    int          lat;
    logic [64:0] e;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == glitch_at) begin
        A     = 32'd8;
        B     = 32'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (lat == 1 && !done) begin
        chk("busy_run", {63'd0, busy}, 64'd1);
        chk("out_held", out, last_out);
      end
    end while (!done && lat < 200);
    chk("latency", lat, exp_lat);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL sb_underflow observed=done expected=no_done");
    end else begin
      e = sb_q.pop_front();
      chk("out", out, e[63:0]);
      chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e[64]});
      chk("sign_flag", {63'd0, Sign_Flag}, {63'd0, e[63]});
      chk("zero_flag", {63'd0, Zero_Flag}, {63'd0, (e[63:0] == 64'd0)});
      chk("busy_done", {63'd0, busy}, 64'd0);
      last_out = e[63:0];
    end
  endtask

  initial begin
    int          pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    n_checks  = 0;
    n_errors  = 0;
    last_out  = 64'd0;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    A         = 32'd0;
    B         = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_zero", {63'd0, Zero_Flag}, 64'd1);
    chk("rst_sign", {63'd0, Sign_Flag}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    rst = 1'b0;

    // Basic, divide-by-zero, zero and full-scale operands.
    issue(32'd100, 32'd7, 1'b0, 1'b1);               wait_done(33, 0);
    chk("t1_literal", out, {32'd2, 32'd14});
    issue(32'd5, 32'd0, 1'b0, 1'b1);                 wait_done(1, 0);
    chk("t2_literal", out, {32'd5, 32'hFFFF_FFFF});
    issue(32'd0, 32'd9, 1'b0, 1'b1);                 wait_done(33, 0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);         wait_done(33, 0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_done(33, 0);
    chk("t3_literal", out, {32'd0, 32'd1});

    // Start pulse during a run is ignored.
    issue(32'd1000, 32'd3, 1'b0, 1'b1);              wait_done(33, 4);
    chk("t4_literal", out, {32'd1, 32'd333});

    // Reset mid-division aborts without a done pulse.
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_out", out, 64'd0);
    chk("abort_zero", {63'd0, Zero_Flag}, 64'd1);
    chk("abort_done", {63'd0, done}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 64'd0);
    last_out = 64'd0;

    // Back-to-back: each issue lands in the previous done cycle.
    issue(32'd60, 32'd5, 1'b0, 1'b1);                wait_done(33, 0);
    issue(32'd50, 32'd5, 1'b0, 1'b1);                wait_done(33, 0);
    chk("t5_literal", out, {32'd0, 32'd10});

`ifdef ALU_DIV_SIGNED_EN
    issue(-32'sd7, 32'd2, 1'b1, 1'b1);               wait_done(33, 0);
    chk("s_m7_2", out, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done(33, 0);
    chk("s_ovf", out, {32'd0, 32'h8000_0000});
    issue(-32'sd9, 32'd0, 1'b1, 1'b1);               wait_done(1, 0);
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
`ifdef ALU_DIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      issue(ra, rb, rs, 1'b1);
      wait_done((rb == 32'd0) ? 1 : 33, 0);
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
